// File: rtl/delay_timer_if.sv
// START/RDY handshake bundle between a control FSM (master) and its delay timer (slave).
interface delay_timer_if #(
  parameter int WIDTH = 16
);
  logic             START;
  logic [WIDTH-1:0] LOAD;
  logic             ABORT;
  logic             RDY;
  logic             BUSY;
  logic [WIDTH-1:0] COUNT;

  modport master (
    output START, LOAD, ABORT,
    input  RDY, BUSY, COUNT
  );

  modport slave (
    input  START, LOAD, ABORT,
    output RDY, BUSY, COUNT
  );
endinterface

// File: rtl/delay_timer.sv
// Programmable countdown timer: counts LOAD ticks of PRESCALE clocks each, then
// pulses RDY for one cycle. Outputs are registered from the next-state decode.
module delay_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1000
) (
  input  logic          clk,
  input  logic          reset,
  delay_timer_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] TICK_AT = PW'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_nxt;
  logic             r_rdy;
  logic             r_busy;
  logic [WIDTH-1:0] r_count;
  logic             w_tick;

  assign w_tick = (r_presc == TICK_AT);

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_presc_nxt = r_presc;
    case (r_state)
      S_IDLE: begin
        if (bus.START && !bus.ABORT) begin
          w_rem_nxt   = bus.LOAD;
          w_presc_nxt = '0;
          w_state_nxt = (bus.LOAD != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // ABORT outranks a completing tick in the same cycle
        if (bus.ABORT) begin
          w_state_nxt = S_IDLE;
          w_rem_nxt   = '0;
          w_presc_nxt = '0;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          if (r_rem != '0) begin
            w_rem_nxt = r_rem - WIDTH'(1);
          end
          if (r_rem <= WIDTH'(1)) begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = '0;
        w_presc_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = '0;
        w_presc_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_presc <= '0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_presc <= w_presc_nxt;
      // Outputs track the state being entered so they are flop outputs, not decode
      r_rdy   <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt == S_RUN);
      r_count <= (w_state_nxt == S_RUN) ? w_rem_nxt : '0;
    end
  end

  assign bus.RDY   = r_rdy;
  assign bus.BUSY  = r_busy;
  assign bus.COUNT = r_count;

endmodule
